// File: rtl/alu_z_stage_if.sv
// alu_z_stage_if: bundles the control-unit handshake, operand inputs and the
// Z register/flag outputs of the ALU execute stage.
//   master modport: control unit side (drives start/op/a/b, observes results)
//   slave  modport: ALU stage side (consumes request, drives busy/done/z/flags)
interface alu_z_stage_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        op_err;
  logic [31:0] z;
  logic        zero_f;
  logic        neg_f;

  modport master (
    output start, op, a, b,
    input  busy, done, op_err, z, zero_f, neg_f
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, op_err, z, zero_f, neg_f
  );
endinterface

// File: rtl/alu_z_stage.sv
// alu_z_stage: sequential ALU execute stage feeding the Z register.
//   Logical/negate ops (AND, OR, NOT, NEG) complete on the accept edge; shifts
//   and rotates step one bit per cycle. Result lands in z with registered
//   zero_f / neg_f flags; done pulses for one cycle, op_err flags an illegal op.
// Ports:
//   clk    - rising-edge clock
//   clr_n  - asynchronous active-low reset
//   bus    - alu_z_stage_if.slave: start, op[3:0], a[31:0], b[31:0] in;
//            busy, done, op_err, z[31:0], zero_f, neg_f out
// Build option:
//   ALU_ROTATE_EN - when defined, op 7 (ROL) and op 8 (ROR) are implemented;
//                   otherwise they are illegal ops.
module alu_z_stage (
  input  logic          clk,
  input  logic          clr_n,
  alu_z_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_NOT  = 4'd2,
    OP_NEG  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_SHRA = 4'd6,
    OP_ROL  = 4'd7,
    OP_ROR  = 4'd8
  } op_t;

`ifdef ALU_ROTATE_EN
  localparam logic [3:0] LAST_OP = OP_ROR;
`else
  localparam logic [3:0] LAST_OP = OP_SHRA;
`endif

  state_t      state, state_nx;
  logic [3:0]  op_q;
  logic        err_q;
  logic [31:0] work;
  logic [4:0]  cnt;
  logic [31:0] z_q;
  logic        zero_q;
  logic        neg_q;

  logic        accept;
  logic        legal_in;
  logic        shift_in;
  logic [4:0]  amt_in;
  logic [31:0] logic_res;
  logic [31:0] step_res;
  logic        z_we;
  logic [31:0] z_nx;

  assign accept   = bus.start && (state == IDLE);
  assign amt_in   = bus.b[4:0];
  // Everything from SHL up to the last implemented op is a bit-serial op.
  assign legal_in = (bus.op <= LAST_OP);
  assign shift_in = (bus.op >= OP_SHL) && (bus.op <= LAST_OP);

  always_comb begin
    logic_res = '0;
    case (bus.op)
      OP_AND:  logic_res = bus.a & bus.b;
      OP_OR:   logic_res = bus.a | bus.b;
      OP_NOT:  logic_res = ~bus.a;
      OP_NEG:  logic_res = ~bus.a + 32'd1;
      default: logic_res = '0;
    endcase
  end

  // One-bit step of the work register; SHRA replicates work[31], which still
  // holds the original a[31] since it is never overwritten.
  always_comb begin
    step_res = work;
    case (op_q)
      OP_SHL:  step_res = {work[30:0], 1'b0};
      OP_SHR:  step_res = {1'b0, work[31:1]};
      OP_SHRA: step_res = {work[31], work[31:1]};
`ifdef ALU_ROTATE_EN
      OP_ROL:  step_res = {work[30:0], work[31]};
      OP_ROR:  step_res = {work[0], work[31:1]};
`endif
      default: step_res = work;
    endcase
  end

  always_comb begin
    state_nx = state;
    z_we     = 1'b0;
    z_nx     = z_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (shift_in && (amt_in != 5'd0)) begin
            state_nx = SHIFT;
          end else begin
            state_nx = DONE;
            if (shift_in) begin
              z_we = 1'b1;
              z_nx = bus.a;
            end else if (legal_in) begin
              z_we = 1'b1;
              z_nx = logic_res;
            end
          end
        end
      end
      SHIFT: begin
        if (cnt == 5'd1) begin
          state_nx = DONE;
          z_we     = 1'b1;
          z_nx     = step_res;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      op_q  <= '0;
      err_q <= 1'b0;
      work  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      op_q  <= bus.op;
      err_q <= !legal_in;
      work  <= bus.a;
      cnt   <= amt_in;
    end else if (state == SHIFT) begin
      work <= step_res;
      cnt  <= cnt - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      z_q    <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (z_we) begin
      z_q    <= z_nx;
      zero_q <= (z_nx == '0);
      neg_q  <= z_nx[31];
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.op_err = (state == DONE) && err_q;
  assign bus.z      = z_q;
  assign bus.zero_f = zero_q;
  assign bus.neg_f  = neg_q;

endmodule

// File: tb/tb_alu_z_stage.sv
// tb_alu_z_stage: directed plus randomized checks of alu_z_stage against an
// arithmetic reference model. Honours ALU_ROTATE_EN the same way as the DUT.
module tb_alu_z_stage;

  logic clk;
  logic clr_n;
  alu_z_stage_if bus ();

  alu_z_stage dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference state: what z and the flags should hold right now.
  logic [31:0] m_z;
  logic        m_zf;
  logic        m_nf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Result of an op computed directly from its definition.
  function automatic void ref_op(input int o, input logic [31:0] av, input logic [31:0] bv,
                                 output logic [31:0] res, output bit err, output int lat);
    int unsigned n;
    bit rot_ok;
    n = bv[4:0];
`ifdef ALU_ROTATE_EN
    rot_ok = 1;
`else
    rot_ok = 0;
`endif
    err = 0;
    lat = 0;
    res = m_z;
    case (o)
      0: res = av & bv;
      1: res = av | bv;
      2: res = ~av;
      3: res = 32'd0 - av;
      4: begin res = av << n; lat = n; end
      5: begin res = av >> n; lat = n; end
      6: begin res = $unsigned($signed(av) >>> n); lat = n; end
      7, 8: begin
        if (rot_ok) begin
          lat = n;
          if (n == 0) res = av;
          else if (o == 7) res = (av << n) | (av >> (32 - n));
          else res = (av >> n) | (av << (32 - n));
        end else begin
          err = 1;
        end
      end
      default: err = 1;
    endcase
  endfunction

  // Issues one op starting at the current negedge; returns at the negedge
  // after done has dropped, so ops can run back to back.
  task automatic run_op(input int o, input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] exp_z;
    logic [31:0] old_z;
    bit exp_err;
    int lat;
    int k;
    ref_op(o, av, bv, exp_z, exp_err, lat);
    old_z = m_z;
    bus.start = 1'b1;
    bus.op = 4'(o);
    bus.a = av;
    bus.b = bv;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    k = 0;
    while (!bus.done && k < 40) begin
      check("busy_mid", 32'(bus.busy), 32'd1);
      check("z_mid", bus.z, old_z);
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(lat));
    check("done", 32'(bus.done), 32'd1);
    check("busy_done", 32'(bus.busy), 32'd1);
    check("op_err", 32'(bus.op_err), 32'(exp_err));
    if (!exp_err) begin
      m_z = exp_z;
      m_zf = (exp_z == 32'd0);
      m_nf = exp_z[31];
    end
    check("z", bus.z, m_z);
    check("zero_f", 32'(bus.zero_f), 32'(m_zf));
    check("neg_f", 32'(bus.neg_f), 32'(m_nf));
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int k;
    checks = 0;
    failures = 0;
    m_z = '0;
    m_zf = 1'b0;
    m_nf = 1'b0;
    clr_n = 1'b0;
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;

    repeat (2) @(negedge clk);
    check("rst_z", bus.z, 32'd0);
    check("rst_zero_f", 32'(bus.zero_f), 32'd0);
    check("rst_neg_f", 32'(bus.neg_f), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_op_err", 32'(bus.op_err), 32'd0);
    clr_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    check("and_val", bus.z, 32'h00F0_1234);
    run_op(1, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run_op(2, 32'hF0F0_1234, 32'h0);
    run_op(3, 32'h0000_0001, 32'h0);
    check("neg1_val", bus.z, 32'hFFFF_FFFF);
    run_op(3, 32'h0, 32'h0);
    check("neg0_zf", 32'(bus.zero_f), 32'd1);
    run_op(3, 32'h8000_0000, 32'h0);
    run_op(6, 32'h8000_0010, 32'hFFFF_FFE4);
    check("shra_val", bus.z, 32'hF800_0001);
    run_op(4, 32'h1357_9BDF, 32'hFFFF_FFE0);
    run_op(7, 32'h8000_0001, 32'd31);
    run_op(8, 32'h8000_0001, 32'd1);
    run_op(1, 32'h1234, 32'h0);
    run_op(12, 32'hDEAD_BEEF, 32'h5);
    check("illegal_hold", bus.z, 32'h0000_1234);
    run_op(5, 32'hFFFF_FFFF, 32'd31);

    // Requests during SHIFT and DONE must be dropped.
    bus.start = 1'b1;
    bus.op = 4'd5;
    bus.a = 32'hF000_0000;
    bus.b = 32'd20;
    @(posedge clk);
    @(negedge clk);
    bus.op = 4'd0;
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'hFFFF_FFFF;
    k = 0;
    while (!bus.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("ign_latency", 32'(k), 32'd20);
    check("ign_z", bus.z, 32'h0000_0F00);
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_busy", 32'(bus.busy), 32'd0);
    check("ign_done", 32'(bus.done), 32'd0);
    check("ign_z_hold", bus.z, 32'h0000_0F00);
    m_z = 32'h0000_0F00;
    m_zf = 1'b0;
    m_nf = 1'b0;
    @(negedge clk);
    check("ign_idle", 32'(bus.busy), 32'd0);

    // Reset in the middle of a shift aborts without a done pulse.
    bus.start = 1'b1;
    bus.op = 4'd5;
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'd20;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 clr_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_z", bus.z, 32'd0);
    check("arst_zero_f", 32'(bus.zero_f), 32'd0);
    check("arst_neg_f", 32'(bus.neg_f), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_done", 32'(bus.done), 32'd0);
    end
    clr_n = 1'b1;
    m_z = '0;
    m_zf = 1'b0;
    m_nf = 1'b0;
    @(negedge clk);
    run_op(2, 32'h0F0F_0F0F, 32'h0);

    // Randomized sweep over all op codes including illegal ones.
    for (int i = 0; i < 150; i++) begin
      int o;
      logic [31:0] av;
      logic [31:0] bv;
      o = $urandom_range(0, 15);
      av = $urandom;
      bv = $urandom;
      if ($urandom_range(0, 3) == 0) bv[4:0] = 5'd0;
      run_op(o, av, bv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
